// File: rtl/lstm_seq_controller.sv
// Time-multiplexes one combinational LSTM cell over SEQ_LEN characters, then
// scans the final prediction for its argmax. Define LSTM_STATE_KEEP_EN to add state_clr.
module lstm_seq_controller #(
    parameter int SEQ_LEN  = 4,
    parameter int HIDDEN   = 25,
    parameter int ENC      = 27,
    parameter int BW       = 32,
    parameter int CELL_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef LSTM_STATE_KEEP_EN
    input  logic                 state_clr,
`endif
    input  logic [BW*ENC-1:0]    char_in,
    input  logic                 char_valid,
    output logic                 char_ready,
    output logic [BW*ENC-1:0]    cell_char,
    output logic [BW*HIDDEN-1:0] cell_h,
    output logic [BW*HIDDEN-1:0] cell_c,
    input  logic [BW*HIDDEN-1:0] cell_h_upd,
    input  logic [BW*HIDDEN-1:0] cell_c_upd,
    input  logic [BW*ENC-1:0]    cell_pred,
    output logic [BW-1:0]        cmp_num1,
    output logic [BW-1:0]        cmp_num2,
    input  logic [1:0]           cmp_result,
    output logic [BW*ENC-1:0]    pred,
    output logic [5:0]           predicted_char,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int STEP_W = $clog2(SEQ_LEN + 1);
    localparam int CNT_W  = $clog2(CELL_LAT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, COMMIT, ARGMAX, DONE} state_t;
    state_t state, state_nxt;

    logic [BW*HIDDEN-1:0] h_r, c_r;
    logic [BW*ENC-1:0]    char_r, pred_r;
    logic [STEP_W-1:0]    step_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [5:0]           idx_r, maxpos_r, pchar_r;
    logic [BW-1:0]        maxval_r, cand;
    logic                 clear_state, settle_done, last_step, scan_end, cand_wins;
    logic                 unused_cmp;

`ifdef LSTM_STATE_KEEP_EN
    assign clear_state = state_clr;
`else
    assign clear_state = 1'b1;
`endif

    assign settle_done = (cnt_r == CNT_W'(CELL_LAT - 1));
    assign last_step   = (step_r == STEP_W'(SEQ_LEN - 1));
    assign scan_end    = (idx_r == 6'(ENC - 1));
    assign cand_wins   = cmp_result[0];
    assign unused_cmp  = cmp_result[1];

    assign cell_char      = char_r;
    assign cell_h         = h_r;
    assign cell_c         = c_r;
    assign pred           = pred_r;
    assign predicted_char = pchar_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        char_ready = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                char_ready = 1'b1;
                if (char_valid) state_nxt = SETTLE;
            end
            SETTLE: if (settle_done) state_nxt = COMMIT;
            COMMIT: state_nxt = last_step ? ARGMAX : LOAD;
            ARGMAX: if (scan_end) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Entry selector feeding the shared comparator with the current candidate.
    always_comb begin
        cand = '0;
        for (int unsigned i = 0; i < ENC; i++)
            if (idx_r == 6'(i)) cand = pred_r[i*BW +: BW];
    end

    assign cmp_num1 = (state == ARGMAX) ? cand     : '0;
    assign cmp_num2 = (state == ARGMAX) ? maxval_r : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_r      <= '0;
            c_r      <= '0;
            char_r   <= '0;
            pred_r   <= '0;
            step_r   <= '0;
            cnt_r    <= '0;
            idx_r    <= '0;
            maxpos_r <= '0;
            maxval_r <= '0;
            pchar_r  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    step_r <= '0;
                    if (clear_state) begin
                        h_r <= '0;
                        c_r <= '0;
                    end
                end
                LOAD: if (char_valid) begin
                    char_r <= char_in;
                    cnt_r  <= '0;
                end
                SETTLE: cnt_r <= cnt_r + CNT_W'(1);
                COMMIT: begin
                    h_r    <= cell_h_upd;
                    c_r    <= cell_c_upd;
                    pred_r <= cell_pred;
                    step_r <= step_r + STEP_W'(1);
                    if (last_step) begin
                        idx_r    <= 6'd1;
                        maxval_r <= cell_pred[BW-1:0];
                        maxpos_r <= '0;
                    end
                end
                ARGMAX: begin
                    // Strict greater-than keeps the lower index on ties.
                    if (cand_wins) begin
                        maxval_r <= cand;
                        maxpos_r <= idx_r;
                    end
                    if (scan_end) pchar_r <= cand_wins ? idx_r : maxpos_r;
                    else          idx_r   <= idx_r + 6'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_seq_controller.sv
// Self-checking bench for lstm_seq_controller: stub cell and comparator, a
// timeline-based reference model, and directed sequences with literal expectations.
module tb_lstm_seq_controller;

    localparam int SEQ_LEN  = 4;
    localparam int HIDDEN   = 25;
    localparam int ENC      = 27;
    localparam int BW       = 32;
    localparam int CELL_LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 start = 1'b0;
    logic [BW*ENC-1:0]    char_in = '0;
    logic                 char_valid = 1'b0;
    logic                 char_ready;
    logic [BW*ENC-1:0]    cell_char;
    logic [BW*HIDDEN-1:0] cell_h, cell_c, cell_h_upd, cell_c_upd;
    logic [BW*ENC-1:0]    cell_pred;
    logic [BW-1:0]        cmp_num1, cmp_num2;
    logic [1:0]           cmp_result;
    logic [BW*ENC-1:0]    pred;
    logic [5:0]           predicted_char;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic                 busy;
    logic [BW*ENC-1:0]    pred_pat = '0;
`ifdef LSTM_STATE_KEEP_EN
    logic                 state_clr = 1'b1;
`endif

    lstm_seq_controller #(
        .SEQ_LEN(SEQ_LEN), .HIDDEN(HIDDEN), .ENC(ENC), .BW(BW), .CELL_LAT(CELL_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef LSTM_STATE_KEEP_EN
        .state_clr(state_clr),
`endif
        .char_in(char_in), .char_valid(char_valid), .char_ready(char_ready),
        .cell_char(cell_char), .cell_h(cell_h), .cell_c(cell_c),
        .cell_h_upd(cell_h_upd), .cell_c_upd(cell_c_upd), .cell_pred(cell_pred),
        .cmp_num1(cmp_num1), .cmp_num2(cmp_num2), .cmp_result(cmp_result),
        .pred(pred), .predicted_char(predicted_char),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    // Stub cell: h entry i gains i+1 per step, c entries gain 3; prediction is a fixed pattern.
    always_comb begin
        for (int i = 0; i < HIDDEN; i++) begin
            cell_h_upd[i*BW +: BW] = cell_h[i*BW +: BW] + BW'(i + 1);
            cell_c_upd[i*BW +: BW] = cell_c[i*BW +: BW] + BW'(3);
        end
    end
    assign cell_pred  = pred_pat;
    assign cmp_result = {1'b0, cmp_num1 > cmp_num2};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
    endtask

    task automatic chk_vec(input string nm, input logic [BW*ENC-1:0] got,
                           input logic [BW*ENC-1:0] exp, input int n);
        int first;
        n_checks++;
        if (got === exp) n_pass++;
        else begin
            first = 0;
            for (int k = n - 1; k >= 0; k--)
                if (got[k*BW +: BW] !== exp[k*BW +: BW]) first = k;
            $display("FAIL %s entry %0d: got %h expected %h at t=%0t", nm, first,
                     got[first*BW +: BW], exp[first*BW +: BW], $time);
        end
    endtask

    function automatic logic [BW*ENC-1:0] exp_h(input int n);
        logic [BW*ENC-1:0] v = '0;
        for (int i = 0; i < HIDDEN; i++) v[i*BW +: BW] = BW'(n * (i + 1));
        return v;
    endfunction

    function automatic logic [BW*ENC-1:0] exp_c(input int n);
        logic [BW*ENC-1:0] v = '0;
        for (int i = 0; i < HIDDEN; i++) v[i*BW +: BW] = BW'(3 * n);
        return v;
    endfunction

    function automatic int ref_argmax(input logic [BW*ENC-1:0] p);
        int best = 0;
        for (int j = 1; j < ENC; j++)
            if (p[j*BW +: BW] > p[best*BW +: BW]) best = j;
        return best;
    endfunction

    function automatic logic [BW-1:0] prefix_max(input logic [BW*ENC-1:0] p, input int j);
        logic [BW-1:0] m = p[BW-1:0];
        for (int k = 1; k < j; k++)
            if (p[k*BW +: BW] > m) m = p[k*BW +: BW];
        return m;
    endfunction

    // Reference model: cycle k is the interval after rising edge k.
    int cyc = 0;
    bit m_busy;
    int ready_from, valid_from, commit_at, argmax_start, m_n, m_steps, m_pchar;
    logic [BW*ENC-1:0] m_char, m_pred;

    task automatic model_reset();
        m_busy = 0; ready_from = -1; valid_from = -1; commit_at = -1; argmax_start = -1;
        m_n = 0; m_steps = 0; m_pchar = 0; m_char = '0; m_pred = '0;
    endtask

    always @(posedge clk) begin
        int e;
        if (rst_n) begin
            e = cyc + 1;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_steps = 0; ready_from = e;
`ifdef LSTM_STATE_KEEP_EN
                    if (state_clr) m_n = 0;
`else
                    m_n = 0;
`endif
                end
            end else begin
                if (valid_from >= 0 && cyc >= valid_from && out_ready) begin
                    m_busy = 0; valid_from = -1; argmax_start = -1;
                end
                if (ready_from >= 0 && cyc >= ready_from && char_valid) begin
                    m_char = char_in; ready_from = -1; commit_at = e + CELL_LAT + 1;
                end
                if (commit_at == e) begin
                    m_n++; m_steps++; m_pred = pred_pat; commit_at = -1;
                    if (m_steps == SEQ_LEN) begin
                        argmax_start = e; valid_from = e + ENC - 1;
                    end else ready_from = e;
                end
                if (valid_from == e) m_pchar = ref_argmax(m_pred);
            end
            cyc = e;
        end
    end

    always @(negedge clk) begin
        int j;
        logic [BW-1:0] e1, e2;
        e1 = '0; e2 = '0;
        if (argmax_start >= 0 && cyc >= argmax_start && cyc < valid_from) begin
            j  = cyc - argmax_start + 1;
            e1 = m_pred[j*BW +: BW];
            e2 = prefix_max(m_pred, j);
        end
        chk("busy", busy, m_busy);
        chk("char_ready", char_ready, ready_from >= 0 && cyc >= ready_from);
        chk("out_valid", out_valid, valid_from >= 0 && cyc >= valid_from);
        chk_vec("cell_char", cell_char, m_char, ENC);
        chk_vec("cell_h", cell_h, exp_h(m_n), HIDDEN);
        chk_vec("cell_c", cell_c, exp_c(m_n), HIDDEN);
        chk_vec("pred", pred, m_pred, ENC);
        chk("predicted_char", predicted_char, m_pchar);
        chk("cmp_num1", cmp_num1, e1);
        chk("cmp_num2", cmp_num2, e2);
    end

    function automatic logic [BW*ENC-1:0] char_pat(input int c);
        logic [BW*ENC-1:0] v = '0;
        v[(c+5)*BW +: BW] = 32'h3F80_0000;
        v[BW-1:0]         = BW'(c + 1);
        return v;
    endfunction

    int acc[SEQ_LEN];

    task automatic run_seq(input logic [BW*ENC-1:0] pat, input int hold, input bit poke,
                           input bit clr, input int exp_h0, input int exp_char);
        int t;
        pred_pat = pat;
`ifdef LSTM_STATE_KEEP_EN
        state_clr = clr;
`else
        if (clr) t = 0;
`endif
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("first_step_h0", cell_h[BW-1:0], exp_h0);
        for (int c = 0; c < SEQ_LEN; c++) begin
            t = 0;
            while (char_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
            chk("ready_wait", char_ready, 1);
            if (c > 0) chk("ready_gap", cyc - acc[c-1], 5);
            for (int k = 0; k < hold && c == 0; k++) begin
                @(negedge clk);
                chk("hold_ready", char_ready, 1);
            end
            char_in = char_pat(c); char_valid = 1'b1;
            acc[c] = cyc + 1;
            @(negedge clk); char_valid = 1'b0;
            if (poke && c == 1) begin
                start = 1'b1; @(negedge clk); start = 1'b0;
            end
        end
        t = 0;
        while (out_valid !== 1'b1 && t < 100) begin
            @(negedge clk); t++;
            start = poke && (t == 15);
        end
        start = 1'b0;
        chk("valid_wait", out_valid, 1);
        chk("valid_latency", cyc - acc[SEQ_LEN-1], 31);
        chk("result_char", predicted_char, exp_char);
        repeat (8) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_char", predicted_char, exp_char);
        end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("back_idle", busy, 0);
    endtask

    logic [BW*ENC-1:0] pat_nom, pat_tie;

    initial begin
        model_reset();
        pat_nom = '0;
        pat_nom[13*BW +: BW] = 32'h4000_0000;
        pat_tie = '0;
        pat_tie[0*BW +: BW]  = 32'h3E80_0000;
        pat_tie[3*BW +: BW]  = 32'h3F80_0000;
        pat_tie[7*BW +: BW]  = 32'h3F00_0000;
        pat_tie[20*BW +: BW] = 32'h3F80_0000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_pchar", predicted_char, 0);
        chk("reset_h0", cell_h[BW-1:0], 0);
        rst_n = 1'b1;

        run_seq(pat_nom, 0, 0, 1, 0, 13);
`ifdef LSTM_STATE_KEEP_EN
        run_seq(pat_nom, 0, 0, 0, 4, 13);
`endif
        run_seq(pat_tie, 10, 0, 1, 0, 3);
        run_seq(pat_nom, 0, 1, 1, 0, 13);

        // Abort a sequence in the middle of SETTLE.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; char_in = char_pat(2); char_valid = 1'b1;
        @(negedge clk); char_valid = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", char_ready, 0);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_pchar", predicted_char, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);

        run_seq(pat_tie, 0, 0, 1, 0, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/lstm_seq_controller.md
Name: lstm_seq_controller

Overview:
- Sequences one shared combinational LSTM cell across SEQ_LEN time steps, replacing the unrolled per-step cell instances.
- Registers hidden and cell state between steps.
- After the last step, runs an iterative argmax over the final prediction vector using one shared comparator.
- Sits between the character-encoding front end and the forward_pass cell / comparator instances inside the next-word predictor top.

Parameters:
- SEQ_LEN, 4, characters per sequence.
- HIDDEN, 25, hidden/cell state entries.
- ENC, 27, one-hot encoding width (entries).
- BW, 32, bits per float entry.
- CELL_LAT, 4, cycles allowed for the combinational cell to settle (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin a sequence (honoured only in IDLE).
- char_in  in  BW*ENC  encoded character.
- char_valid  in  1  char_in valid.
- char_ready  out  1  controller accepts char_in.
- cell_char  out  BW*ENC  registered character to cell.
- cell_h  out  BW*HIDDEN  registered hidden state to cell.
- cell_c  out  BW*HIDDEN  registered cell state to cell.
- cell_h_upd  in  BW*HIDDEN  cell updated hidden state.
- cell_c_upd  in  BW*HIDDEN  cell updated cell state.
- cell_pred  in  BW*ENC  cell prediction vector.
- cmp_num1  out  BW  comparator operand (candidate).
- cmp_num2  out  BW  comparator operand (current max).
- cmp_result  in  2  comparator result; bit0=1 means num1>num2.
- pred  out  BW*ENC  registered final prediction.
- predicted_char  out  6  argmax index.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. The following clear to 0: h, c, char_reg, pred, predicted_char, step, settle counter, argmax index and max registers. char_ready=0, out_valid=0, busy=0.
- IDLE:
  - start=1 -> clear h and c to 0, step=0, go LOAD.
  - start is ignored in all other states.
- LOAD:
  - char_ready=1.
  - On char_valid&char_ready: char_reg<=char_in, settle counter=0, go SETTLE.
  - With no valid, hold indefinitely.
- SETTLE:
  - char_ready=0; cell inputs are stable from registers.
  - Counter increments each cycle.
  - When counter==CELL_LAT-1, go COMMIT. SETTLE lasts exactly CELL_LAT cycles.
- COMMIT (1 cycle):
  - h<=cell_h_upd, c<=cell_c_upd, pred<=cell_pred, step<=step+1.
  - If step==SEQ_LEN-1, go ARGMAX with idx=1, maxval=cell_pred[0], maxpos=0.
  - Otherwise go LOAD.
- ARGMAX (ENC-1 cycles):
  - cmp_num1=pred[idx], cmp_num2=maxval.
  - If cmp_result[0], then maxval<=pred[idx], maxpos<=idx.
  - idx increments each cycle.
  - After idx==ENC-1: predicted_char<=final maxpos, go DONE.
  - Ties keep the lower index (strict greater-than only).
- DONE:
  - out_valid=1; pred and predicted_char held stable.
  - On out_ready: out_valid drops next cycle, go IDLE.
  - out_ready low -> hold.
- Timing from char accept edge to next char_ready: CELL_LAT+1 cycles.
- Total latency from last char accept to out_valid: CELL_LAT+1+(ENC-1) cycles.
- cmp_num1/cmp_num2 outside ARGMAX: drive 0.
- Widths:
  - step is ceil(log2(SEQ_LEN+1)) bits.
  - idx is 6 bits; ENC<=64 is required.
  - No arithmetic on float data; the block only moves and selects entries.
- Reset mid-operation: immediate return to IDLE, all registers cleared, no out_valid.
- h and c persist across steps only; a new start clears them (see Optional Feature).

Optional Feature:
- Macro LSTM_STATE_KEEP_EN.
- Defined:
  - Adds input state_clr (1 bit).
  - start with state_clr=1 clears h/c; start with state_clr=0 keeps h/c from the previous sequence (stateful streaming).
- Undefined:
  - No state_clr port; every start clears h/c to 0.

Test Plan:
- Reset: assert rst_n=0 mid-SETTLE -> same cycle outputs busy=0, char_ready=0, out_valid=0, predicted_char=0; after release, state IDLE.
- Nominal sequence:
  - Setup: CELL_LAT=4, SEQ_LEN=4; stub cell returns h_upd=h+1 (integer pattern) and pred with entry 13 = 0x40000000, others 0.
  - Required: 4 chars accepted, each char_ready rising 5 cycles after the previous accept.
  - Required: out_valid 4+1+26=31 cycles after the last accept, predicted_char=13.
- Backpressure:
  - char_valid held low 10 cycles in LOAD -> no state change, step unchanged.
  - out_ready low 8 cycles in DONE -> out_valid, pred and predicted_char stable.
- Ties: pred entries 3 and 20 both 0x3F800000 (max) -> predicted_char=3.
- Ignored start: start pulsed during SETTLE and ARGMAX -> no effect; h/c not cleared; result matches the nominal run.
- LSTM_STATE_KEEP_EN: second sequence with state_clr=0 -> first-step cell_h equals the final h of sequence 1; with state_clr=1 -> cell_h=0.
